// File: rtl/mc_sequencer.sv
// mc_sequencer -- multi-cycle RV32I execution sequencer.
//
// Owns PC and the instruction register and steps each instruction through
// IF -> ID -> EX -> (MEM) -> WB. Instruction and data memories use a
// req/valid handshake and may stall for any number of cycles. The existing
// decode / control / register_file / execute blocks hang off its ports.
//
// Optional feature: define MC_SEQ_INSTRET_EN to add a 64-bit retired
// instruction counter on instret_o.
//
// Ports
//   clk, reset            clock, async active-low reset
//   imem_*                fetch handshake (req held until valid)
//   dmem_*                data handshake (req/we/addr/be/wdata registered)
//   pc_o, insn_o          PC and IR of the instruction in flight
//   pcsel_i .. wbsel_i    control signals, funct3_i from decode
//   alu_res_i, rs2data_i  execute result / store source
//   br_taken_i            branch decision
//   wb_en_o, wb_data_o    register-file writeback
//   retire_o              one-cycle pulse per completed instruction
//   misalign_o            sticky misaligned-access flag
//   state_o               FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   instret_o             retired count (MC_SEQ_INSTRET_EN only)
module mc_sequencer #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BOOT_ADDR = 32'h0100_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [AWIDTH-1:0]     imem_addr_o,
  input  logic                  imem_valid_i,
  input  logic [DWIDTH-1:0]     imem_rdata_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [AWIDTH-1:0]     dmem_addr_o,
  output logic [DWIDTH/8-1:0]   dmem_be_o,
  output logic [DWIDTH-1:0]     dmem_wdata_o,
  input  logic                  dmem_valid_i,
  input  logic [DWIDTH-1:0]     dmem_rdata_i,
  output logic [AWIDTH-1:0]     pc_o,
  output logic [DWIDTH-1:0]     insn_o,
  input  logic                  pcsel_i,
  input  logic                  memren_i,
  input  logic                  memwren_i,
  input  logic                  regwren_i,
  input  logic [1:0]            wbsel_i,
  input  logic [2:0]            funct3_i,
  input  logic [DWIDTH-1:0]     alu_res_i,
  input  logic [DWIDTH-1:0]     rs2data_i,
  input  logic                  br_taken_i,
  output logic                  wb_en_o,
  output logic [DWIDTH-1:0]     wb_data_o,
  output logic                  retire_o,
  output logic                  misalign_o,
  output logic [2:0]            state_o
`ifdef MC_SEQ_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

  state_t              state, state_nx;
  logic [AWIDTH-1:0]   pc;
  logic [DWIDTH-1:0]   ir;
  logic [DWIDTH-1:0]   aluout;
  logic                br;
  logic [DWIDTH-1:0]   mdr;
  // Current instruction hit a misaligned access: skip request and writeback.
  logic                mis_cur;

  logic [AWIDTH-1:0]   pc_plus4;
  logic [AWIDTH-1:0]   pc_next;
  logic                mis_ex;
  logic [3:0]          be_st;
  logic [DWIDTH-1:0]   wdata_st;
  logic [DWIDTH-1:0]   ld_shift;
  logic [DWIDTH-1:0]   ld_ext;

  assign pc_o        = pc;
  assign insn_o      = ir;
  assign imem_addr_o = pc;
  assign state_o     = state;

  assign pc_plus4 = pc + PC_STEP;
  assign pc_next  = (pcsel_i | br) ? {aluout[AWIDTH-1:1], 1'b0} : pc_plus4;

  // Alignment check uses the live ALU result so the decision is made on the
  // same edge that enters MEM; funct3[1:0] = 0 byte, 1 half, 2 word.
  always_comb begin
    mis_ex = 1'b0;
    case (funct3_i[1:0])
      2'b01:   mis_ex = alu_res_i[0];
      2'b10:   mis_ex = |alu_res_i[1:0];
      default: mis_ex = 1'b0;
    endcase
  end

  // Store lane encoding; data is replicated so any enabled lane carries it.
  always_comb begin
    be_st    = 4'b1111;
    wdata_st = rs2data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_st    = 4'b0001 << alu_res_i[1:0];
        wdata_st = {4{rs2data_i[7:0]}};
      end
      2'b01: begin
        be_st    = 4'b0011 << alu_res_i[1:0];
        wdata_st = {2{rs2data_i[15:0]}};
      end
      default: begin
        be_st    = 4'b1111;
        wdata_st = rs2data_i;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign ld_shift = dmem_rdata_i >> {aluout[1:0], 3'b000};

  always_comb begin
    ld_ext = dmem_rdata_i;
    case (funct3_i)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // Next state and the combinational writeback outputs.
  always_comb begin
    state_nx  = state;
    wb_en_o   = 1'b0;
    retire_o  = 1'b0;
    wb_data_o = '0;
    case (wbsel_i)
      2'd0:    wb_data_o = aluout;
      2'd1:    wb_data_o = mdr;
      2'd2:    wb_data_o = pc_plus4;
      default: wb_data_o = '0;
    endcase
    case (state)
      S_IF:  if (imem_req_o && imem_valid_i) state_nx = S_ID;
      S_ID:  state_nx = S_EX;
      S_EX:  state_nx = (memren_i || memwren_i) ? S_MEM : S_WB;
      S_MEM: if (mis_cur || (dmem_req_o && dmem_valid_i)) state_nx = S_WB;
      S_WB: begin
        state_nx = S_IF;
        retire_o = 1'b1;
        wb_en_o  = regwren_i & ~mis_cur;
      end
      default: state_nx = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IF;
      pc           <= BOOT_ADDR;
      ir           <= '0;
      aluout       <= '0;
      br           <= 1'b0;
      mdr          <= '0;
      mis_cur      <= 1'b0;
      misalign_o   <= 1'b0;
      imem_req_o   <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IF: begin
          // Request goes high one edge into IF after reset; afterwards WB
          // raises it so every later fetch starts with req already up.
          if (imem_req_o && imem_valid_i) begin
            ir         <= imem_rdata_i;
            imem_req_o <= 1'b0;
          end else begin
            imem_req_o <= 1'b1;
          end
        end
        S_EX: begin
          aluout <= alu_res_i;
          br     <= br_taken_i;
          if (memren_i || memwren_i) begin
            if (mis_ex) begin
              mis_cur    <= 1'b1;
              misalign_o <= 1'b1;
            end else begin
              // dmem_wdata_o doubles as the store-data register.
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= memwren_i;
              dmem_addr_o  <= {alu_res_i[AWIDTH-1:2], 2'b00};
              dmem_be_o    <= memwren_i ? be_st : 4'b0000;
              dmem_wdata_o <= memwren_i ? wdata_st : '0;
            end
          end
        end
        S_MEM: begin
          if (!mis_cur && dmem_req_o && dmem_valid_i) begin
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) mdr <= ld_ext;
          end
        end
        S_WB: begin
          pc         <= pc_next;
          mis_cur    <= 1'b0;
          imem_req_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_SEQ_INSTRET_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              instret_o <= '0;
    else if (state == S_WB)  instret_o <= instret_o + 64'd1;
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: stimulus tasks push expected fetch
// addresses, data accesses and retirement records; a monitor pops and
// compares whenever the DUT accepts a fetch, completes a data access or
// retires. The bench plays the role of decode/control/execute by driving
// the control inputs directly for each instruction.
module tb_mc_sequencer;
  localparam logic [31:0] BOOT = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o, imem_valid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        dmem_req_o, dmem_we_o, dmem_valid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] pc_o, insn_o;
  logic        pcsel_i, memren_i, memwren_i, regwren_i, br_taken_i;
  logic [1:0]  wbsel_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, rs2data_i;
  logic        wb_en_o, retire_o, misalign_o;
  logic [31:0] wb_data_o;
  logic [2:0]  state_o;
`ifdef MC_SEQ_INSTRET_EN
  logic [63:0] instret_o;
`endif

  always #5 clk = ~clk;

  mc_sequencer #(.AWIDTH(32), .DWIDTH(32), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_valid_i(dmem_valid_i), .dmem_rdata_i(dmem_rdata_i),
    .pc_o(pc_o), .insn_o(insn_o),
    .pcsel_i(pcsel_i), .memren_i(memren_i), .memwren_i(memwren_i),
    .regwren_i(regwren_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i),
    .alu_res_i(alu_res_i), .rs2data_i(rs2data_i), .br_taken_i(br_taken_i),
    .wb_en_o(wb_en_o), .wb_data_o(wb_data_o), .retire_o(retire_o),
    .misalign_o(misalign_o), .state_o(state_o)
`ifdef MC_SEQ_INSTRET_EN
    , .instret_o(instret_o)
`endif
  );

  typedef struct {
    logic [31:0] insn;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        mis;
    int          lat;
  } ret_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dacc_t;

  ret_t        ret_q[$];
  dacc_t       dacc_q[$];
  logic [31:0] fetch_q[$];

  int checks = 0;
  int errors = 0;

  // memory model configuration, set per instruction
  int          iwait = 0, dwait = 0;
  logic [31:0] cur_insn = '0, drdata = '0;
  logic        exp_mis = 1'b0;
  int          icnt = 0, dcnt = 0, lat = 0;

  assign imem_rdata_i = cur_insn;
  assign dmem_rdata_i = drdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: valid after iwait cycles of a held request.
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_valid_i = 1'b0; icnt = 0;
    end else if (imem_req_o) begin
      imem_valid_i = (icnt >= iwait);
      icnt++;
    end else begin
      imem_valid_i = 1'b0; icnt = 0;
    end
  end

  // Data memory: same scheme with dwait.
  always @(negedge clk) begin
    if (!rst_n) begin
      dmem_valid_i = 1'b0; dcnt = 0;
    end else if (dmem_req_o) begin
      dmem_valid_i = (dcnt >= dwait);
      dcnt++;
    end else begin
      dmem_valid_i = 1'b0; dcnt = 0;
    end
  end

  // Monitor: samples 1 ns after the falling edge, once responders settled.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      lat = 0;
    end else begin
      if (state_o != 3'd0 || imem_req_o) lat++;
      if (imem_req_o && imem_valid_i) begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", 1, 0);
        else chk("fetch_addr", imem_addr_o, fetch_q.pop_front());
      end
      if (dmem_req_o && dmem_valid_i) begin
        if (dacc_q.size() == 0) chk("unexpected_dmem", 1, 0);
        else begin
          dacc_t d;
          d = dacc_q.pop_front();
          chk("dmem_we", dmem_we_o, d.we);
          chk("dmem_addr", dmem_addr_o, d.addr);
          chk("dmem_be", dmem_be_o, d.be);
          if (d.we) chk("dmem_wdata", dmem_wdata_o, d.wdata);
        end
      end
      if (retire_o) begin
        if (ret_q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          ret_t r;
          r = ret_q.pop_front();
          chk("insn", insn_o, r.insn);
          chk("wb_en", wb_en_o, r.wb_en);
          if (r.wb_en) chk("wb_data", wb_data_o, r.wb_data);
          chk("misalign", misalign_o, r.mis);
          chk("latency", lat, r.lat);
        end
        lat = 0;
      end
    end
  end

  task automatic push_d(input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
    dacc_t d;
    d.we = we; d.addr = addr; d.be = be; d.wdata = wdata;
    dacc_q.push_back(d);
  endtask

  // Set up one instruction: control inputs, memory behaviour, expectations.
  task automatic issue(input logic [31:0] insn, input logic [31:0] fpc,
                       input logic pcsel, input logic ren, input logic wen,
                       input logic rwen, input logic [1:0] wbsel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic brt,
                       input int iw, input int dw, input logic [31:0] rd,
                       input logic e_wb_en, input logic [31:0] e_wb_data,
                       input int e_lat);
    ret_t r;
    cur_insn = insn; iwait = iw; dwait = dw; drdata = rd;
    pcsel_i = pcsel; memren_i = ren; memwren_i = wen; regwren_i = rwen;
    wbsel_i = wbsel; funct3_i = f3; alu_res_i = alu; rs2data_i = rs2;
    br_taken_i = brt;
    fetch_q.push_back(fpc);
    r.insn = insn; r.wb_en = e_wb_en; r.wb_data = e_wb_data;
    r.mis = exp_mis; r.lat = e_lat;
    ret_q.push_back(r);
  endtask

  task automatic wait_retire();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (retire_o) break;
    end
    if (n == 100) chk("retire_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    pcsel_i = 0; memren_i = 0; memwren_i = 0; regwren_i = 0;
    wbsel_i = 0; funct3_i = 0; alu_res_i = 0; rs2data_i = 0; br_taken_i = 0;
    imem_valid_i = 0; dmem_valid_i = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc", pc_o, BOOT);
    chk("rst_insn", insn_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_imem_req", imem_req_o, 0);
    chk("rst_dmem_req", dmem_req_o, 0);
    chk("rst_outs", {wb_en_o, retire_o, misalign_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, BOOT);

    //     insn          fetch pc      psel ren wen rwe wbs f3    alu           rs2           br iw dw rdata         wb_en wb_data       lat
    issue(32'h0050_0093, BOOT,         0,   0,  0,  1,  0,  3'd0, 32'd5,        0,            0, 0, 0, 0,            1,    32'd5,        4); wait_retire();
    issue(32'h00A0_0113, BOOT+4,       0,   0,  0,  1,  0,  3'd0, 32'd10,       0,            0, 3, 0, 0,            1,    32'd10,       7); wait_retire();
    push_d(0, 32'h0000_1000, 4'b0000, 0);
    issue(32'h0030_0083, BOOT+8,       0,   1,  0,  1,  1,  3'd0, 32'h1003,     0,            0, 0, 0, 32'h80FF_0000, 1,   32'hFFFF_FF80, 5); wait_retire();
    push_d(0, 32'h0000_1000, 4'b0000, 0);
    issue(32'h0010_4083, BOOT+12,      0,   1,  0,  1,  1,  3'd4, 32'h1001,     0,            0, 0, 2, 32'h1234_5678, 1,   32'h0000_0056, 7); wait_retire();
    push_d(0, 32'h0000_2000, 4'b0000, 0);
    issue(32'h0020_1083, BOOT+16,      0,   1,  0,  1,  1,  3'd1, 32'h2002,     0,            0, 0, 0, 32'h8765_1234, 1,   32'hFFFF_8765, 5); wait_retire();
    push_d(0, 32'h0000_2000, 4'b0000, 0);
    issue(32'h0000_2083, BOOT+20,      0,   1,  0,  1,  1,  3'd2, 32'h2000,     0,            0, 1, 1, 32'hDEAD_BEEF, 1,   32'hDEAD_BEEF, 7); wait_retire();
    push_d(1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
    issue(32'h0020_1123, BOOT+24,      0,   0,  1,  0,  0,  3'd1, 32'h2002,     32'h1234_ABCD, 0, 0, 0, 0,            0,    0,            5); wait_retire();
    push_d(1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5);
    issue(32'h0020_00A3, BOOT+28,      0,   0,  1,  0,  0,  3'd0, 32'h2001,     32'h0000_00A5, 0, 0, 0, 0,            0,    0,            5); wait_retire();
    push_d(1, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D);
    issue(32'h0020_2023, BOOT+32,      0,   0,  1,  0,  0,  3'd2, 32'h3000,     32'hCAFE_F00D, 0, 0, 0, 0,            0,    0,            5); wait_retire();
    // taken BEQ: next fetch at ALUOUT
    issue(32'h0C00_0E63, BOOT+36,      0,   0,  0,  0,  0,  3'd0, 32'h0100_0100, 0,           1, 0, 0, 0,            0,    0,            4); wait_retire();
`ifdef MC_SEQ_INSTRET_EN
    chk("instret_10", instret_o, 64'd10);
`endif
    // JALR to odd target: LSB cleared, link = PC+4
    issue(32'h0010_80E7, 32'h0100_0100, 1, 0,  0,  1,  2,  3'd0, 32'h0100_0201, 0,           0, 0, 0, 0,            1,    32'h0100_0104, 4); wait_retire();
    // not-taken BEQ
    issue(32'h0020_8463, 32'h0100_0200, 0, 0,  0,  0,  0,  3'd0, 32'h0000_5555, 0,           0, 0, 0, 0,            0,    0,            4); wait_retire();
    // misaligned LW: no request, no write, sticky flag
    exp_mis = 1'b1;
    issue(32'h0010_2083, 32'h0100_0204, 0, 1,  0,  1,  1,  3'd2, 32'h2001,     0,            0, 0, 0, 32'h1111_1111, 0,   0,            5); wait_retire();
    // wbsel = 3 writes zero
    issue(32'h0000_0013, 32'h0100_0208, 0, 0,  0,  1,  3,  3'd0, 32'h7777_7777, 0,           0, 0, 0, 0,            1,    32'h0,        4); wait_retire();
    // jump to the last word, then a plain op there wraps PC to 0
    issue(32'h0000_0067, 32'h0100_020C, 1, 0,  0,  0,  0,  3'd0, 32'hFFFF_FFFD, 0,           0, 0, 0, 0,            0,    0,            4); wait_retire();
    issue(32'h0010_0093, 32'hFFFF_FFFC, 0, 0,  0,  1,  0,  3'd0, 32'h0000_0001, 0,           0, 0, 0, 0,            1,    32'h1,        4); wait_retire();

    // reset during a stalled MEM access
    issue(32'h0000_2083, 32'h0000_0000, 0, 1,  0,  1,  1,  3'd2, 32'h4000,     0,            0, 0, 30, 32'h0,        1,   0,            0);
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        @(negedge clk);
        if (state_o == 3'd3) break;
      end
      chk("reach_mem", state_o, 3);
    end
    repeat (3) @(negedge clk);
    chk("mid_dmem_req_before", dmem_req_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_state", state_o, 0);
    chk("mid_pc", pc_o, BOOT);
    chk("mid_dmem_req", dmem_req_o, 0);
    chk("mid_misalign", misalign_o, 0);
    ret_q.delete(); fetch_q.delete(); dacc_q.delete();
    exp_mis = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    issue(32'h0070_0093, BOOT,         0,   0,  0,  1,  0,  3'd0, 32'd7,        0,            0, 0, 0, 0,            1,    32'd7,        4); wait_retire();
    chk("pc_after_recover", pc_o, BOOT + 4);
`ifdef MC_SEQ_INSTRET_EN
    chk("instret_after_reset", instret_o, 64'd1);
`endif
    chk("queues_drained", ret_q.size() + fetch_q.size() + dacc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle execution sequencer for the RV32I core: the next-generation successor to the single-cycle top, which has no writeback, no memory stage and no stall capability. It owns the PC and instruction register and runs a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. It handshakes with instruction and data memories that may stall for any number of cycles, and it closes the writeback path the single-cycle top leaves stubbed. The existing decode, igen, control, register_file, branch_control and execute modules attach to its ports unchanged.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width; fixed at 32 for this block
- BOOT_ADDR, 32'h0100_0000, PC value after reset
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request, held high until accepted
- imem_addr_o  out  AWIDTH  fetch address; equals pc_o
- imem_valid_i  in  1  fetch data valid; the cycle it is high completes the fetch
- imem_rdata_i  in  DWIDTH  fetched instruction
- dmem_req_o  out  1  data request, held high until accepted
- dmem_we_o  out  1  1 = store, 0 = load
- dmem_addr_o  out  AWIDTH  word-aligned address (ALU result with [1:0] cleared)
- dmem_be_o  out  DWIDTH/8  byte enables (stores only; 0 for loads)
- dmem_wdata_o  out  DWIDTH  store data, replicated to the active lanes
- dmem_valid_i  in  1  data access complete
- dmem_rdata_i  in  DWIDTH  load word
- pc_o  out  AWIDTH  PC of the instruction in flight
- insn_o  out  DWIDTH  instruction register, feeding decode
- pcsel_i, memren_i, memwren_i, regwren_i  in  1 each  from control
- wbsel_i  in  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = zero
- funct3_i  in  3  from decode
- alu_res_i  in  DWIDTH  from execute
- rs2data_i  in  DWIDTH  from register_file
- br_taken_i  in  1  branch decision
- wb_en_o  out  1  register-file write enable, for exactly one cycle per retiring instruction
- wb_data_o  out  DWIDTH  writeback data
- retire_o  out  1  one-cycle pulse when an instruction completes
- misalign_o  out  1  sticky flag for a misaligned data access; cleared only by reset
- state_o  out  3  FSM state, for probing: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4

## Operation
- **IF:** assert imem_req_o with imem_addr_o = PC. When imem_valid_i is high, latch imem_rdata_i into IR and go to ID. Otherwise stay in IF.
- **ID:** one cycle. IR is stable so decode, control and igen settle. Go to EX.
- **EX:** one cycle.
  - Latch alu_res_i into ALUOUT, br_taken_i into BR, and rs2data_i into SD.
  - Go to MEM if memren_i or memwren_i is set; otherwise go to WB.
- **MEM, misalign check (on entry):**
  - Halfword is misaligned when ALUOUT[0] = 1.
  - Word is misaligned when ALUOUT[1:0] ≠ 0.
  - On misalignment: set misalign_o, issue no request, go to WB with writeback suppressed.
- **MEM, aligned access:**
  - Hold dmem_req_o high until dmem_valid_i, then go to WB.
  - For a load, latch the lane-extracted data into MDR on that cycle.
- **Load extraction** (byte lane = ALUOUT[1:0]):
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: pass the word through.
- **Store encoding:**
  - SB: be = 4'b0001 << addr[1:0], byte replicated ×4.
  - SH: be = 4'b0011 << addr[1:0], halfword replicated ×2.
  - SW: be = 4'b1111.
- **WB:**
  - wb_en_o = regwren_i unless suppressed by misalignment.
  - wb_data_o is selected by wbsel_i.
  - PC ← (pcsel_i | BR) ? {ALUOUT[AWIDTH-1:1], 1'b0} : PC + 4, with 32-bit wrap.
  - Pulse retire_o and go to IF.
- Control inputs are sampled in EX, MEM and WB from the unchanged IR, so they stay valid throughout.

## Timing
- **Reset values:**
  - State = IF, PC = BOOT_ADDR, IR = 0 (pc_o = BOOT_ADDR, insn_o = 0).
  - All request, enable and pulse outputs are 0; misalign_o = 0.
- imem_req_o rises on the first clock edge after reset is released.
- **Latency with zero-wait memory** (valid in the same cycle as req):
  - ALU, branch and jump instructions: 4 cycles (IF, ID, EX, WB).
  - Loads and stores: 5 cycles.
- Each wait cycle on a memory adds one cycle. There is no timeout.
- Request outputs are registered, so address, byte enables and data are stable for the whole time a request is held.
- imem_valid_i and dmem_valid_i are ignored outside IF and MEM respectively.
- If reset is asserted mid-transaction, the transaction is abandoned. The memories must drop any pending response on reset.
- A fetch from PC 32'hFFFF_FFFC followed by a non-taken instruction wraps PC to 0.

## Configuration
- **MC_SEQ_INSTRET_EN** defined:
  - Adds output instret_o, width 64: a retired-instruction counter that increments on each retire_o.
  - Resets to 0 and wraps at 2^64.
- **Undefined:** the port and the counter are absent.

## Test plan
- **Reset / first fetch:** release reset with imem returning 32'h0050_0093 (addi x1,x0,5) at zero wait.
  - Required: req at PC 32'h0100_0000.
  - Required: wb_en_o in the 4th cycle with wb_data_o = 5, wbsel 0.
  - Required: PC becomes 32'h0100_0004.
- **Instruction-memory stall:** imem_valid_i delayed 3 cycles.
  - Required: imem_req_o and imem_addr_o held steady, state_o = 0 for 4 cycles, retire after 7 cycles.
- **Load byte, sign-extended:** LB at address 32'h0000_1003 with dmem_rdata_i = 32'h80FF_0000.
  - Required: dmem_addr_o = 32'h1000.
  - Required: wb_data_o = 32'hFFFF_FF80.
- **Store halfword:** SH rs2 = 32'h1234_ABCD to address 32'h2002.
  - Required: be = 4'b1100, wdata = 32'hABCD_ABCD, wb_en_o = 0.
- **Branch, jump and misalignment:**
  - Taken BEQ: PC = ALUOUT.
  - JALR to an odd target: LSB cleared, wb_data_o = PC + 4.
  - LW at 32'h2001: misalign_o = 1, no dmem_req_o, no write.
- **Retire counter / reset mid-transaction:** with MC_SEQ_INSTRET_EN defined, 10 retirements give instret_o = 10. Asserting reset during MEM returns the block to IF at BOOT_ADDR with dmem_req_o = 0.
